sched_queue_ctrl: RTL and testbench
===================================

Name: sched_queue_ctrl

Overview:
- Front-end controller that sits directly upstream of the insertion-sort cell array of the hardware scheduler.
- Accepts task descriptors over a valid/ready handshake and serialises three kinds of operation into the array: writes (insert), reads (dispatch the head), and periodic subtract ticks.
- Tracks array occupancy.
- Hands the head task (cell 0) to the dispatcher.

Parameters:
- W, 41, array entry width; bit W-1 is the valid flag, bits [W-2:0] are the task descriptor, bits [31:16] are the sort key.
- DEPTH, 8, number of cells in the array; also the settle time in cycles after each array operation.
- TICK_PERIOD, 1000, clock cycles between subtract requests (minimum 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- task_valid  in  1  upstream task descriptor present
- task_data  in  W-1  task descriptor
- task_ready  out  1  controller will accept task_data this cycle
- disp_req  in  1  dispatcher requests the head task (level)
- disp_valid  out  1  one-cycle pulse; disp_data is valid
- disp_data  out  W-1  dispatched descriptor
- arr_wr  out  1  insert strobe to cell 0
- arr_rd  out  1  shift/read strobe to all cells
- arr_subtract  out  1  subtract strobe to all cells
- arr_data  out  W-1  descriptor driven to cell 0 data input
- head_reg  in  W  cell 0 stored entry (valid flag + descriptor)
- count  out  clog2(DEPTH+1)  current occupancy
- sub_overrun  out  1  sticky: a tick arrived while a previous tick was still pending

Behaviour:
- Reset (async, rst=1) state:
  - FSM in IDLE; all arr_* strobes 0; arr_data all-ones.
  - task_ready=0, disp_valid=0, disp_data all-ones.
  - count=0, tick counter=0, sub_pending=0, sub_overrun=0.
  - A reset mid-operation abandons the operation; the array is reset by the same rst.
- Tick counter:
  - Free-running 0..TICK_PERIOD-1, wraps to 0.
  - On wrap, sub_pending is set.
  - If sub_pending is already 1 at wrap, sub_overrun is set; it is cleared only by reset.
- FSM states: IDLE, OP, SETTLE.
- IDLE arbitration, fixed priority, decided each cycle:
  1. If sub_pending: go to OP with arr_subtract=1; clear sub_pending.
  2. Else if disp_req and count>0: go to OP with arr_rd=1; disp_data<=head_reg[W-2:0] and disp_valid=1 in the same cycle; count decrements.
  3. Else if task_valid and count<DEPTH: task_ready=1 combinationally; on handshake go to OP with arr_wr=1 and arr_data<=task_data; count increments.
  4. Else stay in IDLE.
- task_ready is 1 only in IDLE, with no pending subtract, no serviceable read, and count<DEPTH.
- OP: exactly one array strobe is high for exactly one cycle, registered. The strobes are mutually exclusive (the cells give subtract priority over wr/rd, so overlapping them would lose an insertion). Next state is SETTLE.
- SETTLE: lasts DEPTH cycles with all strobes 0, so an insertion can ripple through the whole array. Then returns to IDLE. Arbitration resumes on the first IDLE cycle.
- Operation spacing: one operation per DEPTH+2 cycles minimum (IDLE + OP + DEPTH settle).
- arr_data holds its last written value when arr_wr=0.
- Empty array: disp_req is ignored (no pulse, count stays 0); disp_req may stay high.
- Full array: task_ready=0; the task waits upstream and no descriptor is dropped.
- disp_valid is high for exactly one cycle per read; disp_data holds its value until the next read.
- Simultaneous tick wrap and IDLE decision: sub_pending is set this cycle and served at the next IDLE decision. The current cycle's arbitration uses the old sub_pending.

Test Plan:
- Reset mid-SETTLE after a write: all outputs return to reset values immediately; count=0; no strobe in the following cycle.
- Insert three tasks (keys 0x0030, 0x0010, 0x0020) with disp_req=0 and a large TICK_PERIOD:
  - three arr_wr pulses spaced DEPTH+2 cycles apart; count=3.
  - Then assert disp_req with head_reg key=0x0010: disp_valid pulses once, disp_data=head_reg[39:0], arr_rd pulses once, count=2.
- Fill to DEPTH=8 with task_valid held high: task_ready stays 0 after the 8th handshake. One read restores task_ready=1 at the next IDLE.
- disp_req=1 with count=0 for 50 cycles: disp_valid=0, arr_rd=0 throughout.
- TICK_PERIOD=4 while task_valid and disp_req are both active:
  - arr_subtract is never concurrent with arr_wr or arr_rd.
  - sub_overrun becomes 1 because DEPTH+2 > 4 lets ticks accumulate.
- With TICK_PERIOD=20, sub_pending and task_valid both present in IDLE: arr_subtract is issued first and arr_wr follows DEPTH+2 cycles later.

Source files
------------

// File: rtl/sched_queue_ctrl.sv
// Front-end controller for the scheduler's insertion-sort cell array.
// Takes task descriptors over valid/ready and issues one array operation at
// a time: insert (arr_wr), dispatch the head (arr_rd) or a periodic subtract
// tick (arr_subtract). Every operation is followed by DEPTH settle cycles so
// an insertion can ripple through the whole array. Tracks occupancy in count.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   task_valid/task_data     upstream descriptor; task_ready accepts it (comb)
//   disp_req                 dispatcher wants the head task (level)
//   disp_valid/disp_data     one-cycle pulse with the dispatched descriptor
//   arr_wr/arr_rd/arr_subtract  mutually exclusive one-cycle array strobes
//   arr_data                 descriptor driven to cell 0 (held between writes)
//   head_reg                 cell 0 entry: {valid, descriptor}
//   count                    current occupancy
//   sub_overrun              sticky: a tick wrapped while one was still pending
module sched_queue_ctrl #(
  parameter int unsigned W           = 41,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TICK_PERIOD = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         task_valid,
  input  logic [W-2:0]                 task_data,
  output logic                         task_ready,
  input  logic                         disp_req,
  output logic                         disp_valid,
  output logic [W-2:0]                 disp_data,
  output logic                         arr_wr,
  output logic                         arr_rd,
  output logic                         arr_subtract,
  output logic [W-2:0]                 arr_data,
  input  logic [W-1:0]                 head_reg,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         sub_overrun
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TICK_PERIOD);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(DEPTH - 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, OP, SETTLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          sub_pending_q, sub_pending_d;
  logic          sub_overrun_q, sub_overrun_d;
  logic          arr_wr_q, arr_wr_d;
  logic          arr_rd_q, arr_rd_d;
  logic          arr_subtract_q, arr_subtract_d;
  logic [W-2:0]  arr_data_q, arr_data_d;
  logic          disp_valid_q, disp_valid_d;
  logic [W-2:0]  disp_data_q, disp_data_d;

  logic tick_wrap;
  logic serve_rd;
  logic sub_clear;

  // Occupancy is tracked by count; the cell's own valid flag is not needed.
  logic unused_head_valid;
  assign unused_head_valid = head_reg[W-1];

  // Next-state, arbitration and tick logic.
  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    count_d        = count_q;
    arr_wr_d       = 1'b0;
    arr_rd_d       = 1'b0;
    arr_subtract_d = 1'b0;
    arr_data_d     = arr_data_q;
    disp_valid_d   = 1'b0;
    disp_data_d    = disp_data_q;
    sub_clear      = 1'b0;

    tick_wrap = (tick_q == TICK_LAST);
    tick_d    = tick_wrap ? '0 : tick_q + TW'(1);
    serve_rd  = disp_req && (count_q != '0);

    // Ready ignores task_valid; it only reflects that a write would win now.
    task_ready = !rst && (state_q == IDLE) && !sub_pending_q && !serve_rd &&
                 (count_q < DEPTH_C);

    unique case (state_q)
      IDLE: begin
        if (sub_pending_q) begin
          arr_subtract_d = 1'b1;
          sub_clear      = 1'b1;
          state_d        = OP;
        end else if (serve_rd) begin
          arr_rd_d     = 1'b1;
          disp_valid_d = 1'b1;
          disp_data_d  = head_reg[W-2:0];
          count_d      = count_q - CW'(1);
          state_d      = OP;
        end else if (task_valid && task_ready) begin
          arr_wr_d   = 1'b1;
          arr_data_d = task_data;
          count_d    = count_q + CW'(1);
          state_d    = OP;
        end
      end
      OP: begin
        settle_d = SETTLE_LAST;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) state_d = IDLE;
        else                settle_d = settle_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // A wrap in the same cycle as a serve re-arms the pending flag; the
    // overrun check uses the pre-serve value.
    sub_pending_d = tick_wrap | (sub_pending_q & ~sub_clear);
    sub_overrun_d = sub_overrun_q | (tick_wrap & sub_pending_q);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      settle_q       <= '0;
      count_q        <= '0;
      tick_q         <= '0;
      sub_pending_q  <= 1'b0;
      sub_overrun_q  <= 1'b0;
      arr_wr_q       <= 1'b0;
      arr_rd_q       <= 1'b0;
      arr_subtract_q <= 1'b0;
      arr_data_q     <= '1;
      disp_valid_q   <= 1'b0;
      disp_data_q    <= '1;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      count_q        <= count_d;
      tick_q         <= tick_d;
      sub_pending_q  <= sub_pending_d;
      sub_overrun_q  <= sub_overrun_d;
      arr_wr_q       <= arr_wr_d;
      arr_rd_q       <= arr_rd_d;
      arr_subtract_q <= arr_subtract_d;
      arr_data_q     <= arr_data_d;
      disp_valid_q   <= disp_valid_d;
      disp_data_q    <= disp_data_d;
    end
  end

  assign arr_wr       = arr_wr_q;
  assign arr_rd       = arr_rd_q;
  assign arr_subtract = arr_subtract_q;
  assign arr_data     = arr_data_q;
  assign disp_valid   = disp_valid_q;
  assign disp_data    = disp_data_q;
  assign count        = count_q;
  assign sub_overrun  = sub_overrun_q;

endmodule

// File: tb/tb_sched_queue_ctrl.sv
// Directed bench for sched_queue_ctrl: three instances with different tick
// periods (5000 for functional tests, 4 for tick overrun, 20 for priority).
module tb_sched_queue_ctrl;

  localparam int unsigned W     = 41;
  localparam int unsigned DEPTH = 8;
  localparam logic [39:0] ONES  = 40'hFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Instance A: functional tests
  logic        a_tv, a_tr, a_dr, a_dv, a_wr, a_rd, a_sub, a_ovr;
  logic [39:0] a_td, a_dd, a_ad;
  logic [40:0] a_hr;
  logic [3:0]  a_cnt;
  // Instance B: TICK_PERIOD=4
  logic        b_tv, b_tr, b_dr, b_dv, b_wr, b_rd, b_sub, b_ovr;
  logic [39:0] b_td, b_dd, b_ad;
  logic [40:0] b_hr;
  logic [3:0]  b_cnt;
  // Instance C: TICK_PERIOD=20
  logic        c_tv, c_tr, c_dr, c_dv, c_wr, c_rd, c_sub, c_ovr;
  logic [39:0] c_td, c_dd, c_ad;
  logic [40:0] c_hr;
  logic [3:0]  c_cnt;

  sched_queue_ctrl #(.W(W), .DEPTH(DEPTH), .TICK_PERIOD(5000)) u_a (
    .clk(clk), .rst(rst), .task_valid(a_tv), .task_data(a_td), .task_ready(a_tr),
    .disp_req(a_dr), .disp_valid(a_dv), .disp_data(a_dd), .arr_wr(a_wr),
    .arr_rd(a_rd), .arr_subtract(a_sub), .arr_data(a_ad), .head_reg(a_hr),
    .count(a_cnt), .sub_overrun(a_ovr));

  sched_queue_ctrl #(.W(W), .DEPTH(DEPTH), .TICK_PERIOD(4)) u_b (
    .clk(clk), .rst(rst), .task_valid(b_tv), .task_data(b_td), .task_ready(b_tr),
    .disp_req(b_dr), .disp_valid(b_dv), .disp_data(b_dd), .arr_wr(b_wr),
    .arr_rd(b_rd), .arr_subtract(b_sub), .arr_data(b_ad), .head_reg(b_hr),
    .count(b_cnt), .sub_overrun(b_ovr));

  sched_queue_ctrl #(.W(W), .DEPTH(DEPTH), .TICK_PERIOD(20)) u_c (
    .clk(clk), .rst(rst), .task_valid(c_tv), .task_data(c_td), .task_ready(c_tr),
    .disp_req(c_dr), .disp_valid(c_dv), .disp_data(c_dd), .arr_wr(c_wr),
    .arr_rd(c_rd), .arr_subtract(c_sub), .arr_data(c_ad), .head_reg(c_hr),
    .count(c_cnt), .sub_overrun(c_ovr));

  function automatic logic [39:0] mk(input logic [15:0] key, input logic [7:0] tag);
    return {tag, key, 16'hBEEF};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [39:0] exp_d [3];
  int wr_cyc [3];
  int idx, n_wr, n_sub, n_cwr, n_csub;
  int c_wr_cyc [8];
  int c_sub_cyc [8];

  initial begin
    a_tv = 0; a_dr = 0; a_td = '0; a_hr = '0;
    b_tv = 0; b_dr = 0; b_td = '0; b_hr = '0;
    c_tv = 0; c_dr = 0; c_td = '0; c_hr = '0;
    exp_d[0] = mk(16'h0030, 8'h10);
    exp_d[1] = mk(16'h0010, 8'h11);
    exp_d[2] = mk(16'h0020, 8'h12);
    for (int i = 0; i < 3; i++) wr_cyc[i] = 0;
    for (int i = 0; i < 8; i++) begin c_wr_cyc[i] = 0; c_sub_cyc[i] = 0; end

    // Reset values
    rst = 1;
    repeat (2) step();
    chk("rst_wr", a_wr, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_sub", a_sub, 0);
    chk("rst_arr_data", a_ad, ONES);
    chk("rst_ready", a_tr, 0);
    chk("rst_dvalid", a_dv, 0);
    chk("rst_ddata", a_dd, ONES);
    chk("rst_count", a_cnt, 0);
    chk("rst_ovr", a_ovr, 0);

    // Reset mid-SETTLE after a write
    rst = 0;
    a_td = mk(16'h0050, 8'h01);
    a_tv = 1;
    step();
    chk("w1_wr", a_wr, 1);
    chk("w1_data", a_ad, mk(16'h0050, 8'h01));
    chk("w1_count", a_cnt, 1);
    chk("w1_ready_op", a_tr, 0);
    a_tv = 0;
    repeat (3) step();
    chk("settle_wr", a_wr, 0);
    #2 rst = 1;
    #1;
    chk("midrst_count", a_cnt, 0);
    chk("midrst_arr_data", a_ad, ONES);
    chk("midrst_wr", a_wr, 0);
    chk("midrst_ready", a_tr, 0);
    step();
    rst = 0;
    step();
    chk("postrst_wr", a_wr, 0);
    chk("postrst_rd", a_rd, 0);
    chk("postrst_sub", a_sub, 0);
    chk("postrst_count", a_cnt, 0);

    // Insert three tasks, spacing DEPTH+2
    idx = 0;
    a_td = exp_d[0];
    a_tv = 1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (a_wr) begin
        if (idx < 3) begin
          wr_cyc[idx] = i;
          chk("ins_data", a_ad, exp_d[idx]);
          idx++;
          if (idx < 3) a_td = exp_d[idx];
          else a_tv = 0;
        end else begin
          chk("ins_extra_wr", a_wr, 0);
        end
      end
    end
    chk("ins_n", idx, 3);
    chk("ins_first", wr_cyc[0], 1);
    chk("ins_gap1", wr_cyc[1] - wr_cyc[0], DEPTH + 2);
    chk("ins_gap2", wr_cyc[2] - wr_cyc[1], DEPTH + 2);
    chk("ins_count", a_cnt, 3);

    // Dispatch the head
    a_hr = {1'b1, exp_d[1]};
    a_dr = 1;
    step();
    chk("rd_dvalid", a_dv, 1);
    chk("rd_ddata", a_dd, exp_d[1]);
    chk("rd_rd", a_rd, 1);
    chk("rd_wr", a_wr, 0);
    chk("rd_sub", a_sub, 0);
    chk("rd_count", a_cnt, 2);
    a_dr = 0;
    step();
    chk("rd_dvalid_pulse", a_dv, 0);
    chk("rd_rd_pulse", a_rd, 0);
    chk("rd_ddata_hold", a_dd, exp_d[1]);
    repeat (8) step();

    // Fill to DEPTH with task_valid held high
    a_td = mk(16'h0040, 8'h20);
    a_tv = 1;
    n_wr = 0;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (a_wr) n_wr++;
    end
    chk("fill_nwr", n_wr, 6);
    chk("fill_count", a_cnt, 8);
    chk("fill_ready", a_tr, 0);
    chk("fill_wr_idle", a_wr, 0);
    a_hr = {1'b1, mk(16'h0005, 8'h30)};
    a_dr = 1;
    step();
    chk("full_rd_dvalid", a_dv, 1);
    chk("full_rd_count", a_cnt, 7);
    a_dr = 0;
    repeat (8) step();
    chk("full_ready_settle", a_tr, 0);
    step();
    chk("full_ready_idle", a_tr, 1);
    step();
    chk("refill_wr", a_wr, 1);
    chk("refill_count", a_cnt, 8);
    chk("a_no_ovr", a_ovr, 0);
    a_tv = 0;
    repeat (10) step();

    // Empty array ignores disp_req
    rst = 1;
    step();
    rst = 0;
    a_dr = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("empty_dvalid", a_dv, 0);
      chk("empty_rd", a_rd, 0);
    end
    chk("empty_count", a_cnt, 0);
    a_dr = 0;

    // TICK_PERIOD=4: exclusivity and overrun
    rst = 1;
    step();
    chk("b_ovr_rst", b_ovr, 0);
    b_tv = 1;
    b_dr = 1;
    b_hr = {1'b1, mk(16'h0007, 8'h40)};
    b_td = mk(16'h0009, 8'h41);
    rst = 0;
    n_sub = 0;
    n_wr = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (b_sub) n_sub++;
      if (b_wr) n_wr++;
      chk("b_excl", b_sub & (b_wr | b_rd), 0);
    end
    chk("b_ovr", b_ovr, 1);
    chk("b_nsub", n_sub, 19);
    chk("b_nwr", n_wr, 1);
    chk("b_count", b_cnt, 1);
    chk("b_ddata_untouched", b_dd, ONES);
    chk("b_arr_data", b_ad, mk(16'h0009, 8'h41));
    chk("b_ready", b_tr, 0);
    chk("b_dvalid", b_dv, 0);
    b_tv = 0;
    b_dr = 0;

    // TICK_PERIOD=20: pending subtract beats a waiting write
    rst = 1;
    step();
    c_tv = 1;
    c_td = mk(16'h0011, 8'h50);
    rst = 0;
    n_cwr = 0;
    n_csub = 0;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (c_wr && n_cwr < 8) begin c_wr_cyc[n_cwr] = i; n_cwr++; end
      if (c_sub && n_csub < 8) begin c_sub_cyc[n_csub] = i; n_csub++; end
      chk("c_rd_idle", c_rd, 0);
    end
    chk("c_nwr", n_cwr, 3);
    chk("c_nsub", n_csub, 2);
    chk("c_wr2", c_wr_cyc[1], 11);
    chk("c_first_sub", c_sub_cyc[0], 21);
    chk("c_wr_after_sub", c_wr_cyc[2] - c_sub_cyc[0], DEPTH + 2);
    chk("c_count", c_cnt, 3);
    chk("c_ovr", c_ovr, 0);
    chk("c_arr_data", c_ad, mk(16'h0011, 8'h50));
    chk("c_dvalid", c_dv, 0);
    chk("c_ddata", c_dd, ONES);
    chk("c_ready", c_tr, 0);
    c_tv = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
